// File: rtl/oai222_bist_ctrl.sv
// OAI222 BIST sequencer: sweeps all 64 input vectors through one cell, holds each
// for SETTLE+1 cycles, compares ZN against the golden function and logs errors.
module oai222_bist_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       START,
  input  logic       ABORT,
  input  logic       ZN_IN,
  output logic       A1,
  output logic       A2,
  output logic       B1,
  output logic       B2,
  output logic       C1,
  output logic       C2,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [6:0] ERR_CNT,
  output logic [5:0] FAIL_VEC
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_vec;
  logic [5:0] w_vec_nxt;
  logic [3:0] r_wcnt;
  logic [3:0] w_wcnt_nxt;
  logic [6:0] r_err_cnt;
  logic [6:0] w_err_nxt;
  logic [5:0] r_fail_vec;
  logic [5:0] w_fail_nxt;
  logic [5:0] r_stim;
  logic [5:0] w_stim_nxt;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pass_nxt;
  logic       w_sample;
  logic       w_exp;
  logic       w_last;
  logic       w_enter;

  // ABORT pre-empts the compare that would otherwise happen on the same edge.
  assign w_sample = (r_state == S_RUN) && !ABORT && (r_wcnt == SETTLE_W);
  assign w_exp    = ~((r_vec[5] | r_vec[4]) & (r_vec[3] | r_vec[2]) & (r_vec[1] | r_vec[0]));
  assign w_last   = (r_vec == 6'd63);
  assign w_enter  = (r_state != S_RUN) && (w_state_nxt == S_RUN);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (START) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (ABORT)                  w_state_nxt = S_IDLE;
        else if (w_sample && w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_vec_nxt  = r_vec;
    w_wcnt_nxt = r_wcnt;
    w_err_nxt  = r_err_cnt;
    w_fail_nxt = r_fail_vec;
    if (w_enter) begin
      w_vec_nxt  = 6'd0;
      w_wcnt_nxt = 4'd0;
      w_err_nxt  = 7'd0;
      w_fail_nxt = 6'd0;
    end else if ((r_state == S_RUN) && !ABORT) begin
      if (!w_sample) begin
        w_wcnt_nxt = r_wcnt + 4'd1;
      end else begin
        w_wcnt_nxt = 4'd0;
        if (ZN_IN != w_exp) begin
          w_err_nxt = r_err_cnt + 7'd1;
          if (r_err_cnt == 7'd0) w_fail_nxt = r_vec;
        end
        // VEC parks at 63 on the final compare rather than wrapping.
        if (!w_last) w_vec_nxt = r_vec + 6'd1;
      end
    end
  end

  always_comb begin
    w_stim_nxt = 6'd0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_pass_nxt = 1'b0;
    case (w_state_nxt)
      S_RUN: begin
        w_stim_nxt = w_vec_nxt;
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
        w_pass_nxt = (w_err_nxt == 7'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_vec      <= 6'd0;
      r_wcnt     <= 4'd0;
      r_err_cnt  <= 7'd0;
      r_fail_vec <= 6'd0;
      r_stim     <= 6'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_vec      <= w_vec_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_err_cnt  <= w_err_nxt;
      r_fail_vec <= w_fail_nxt;
      r_stim     <= w_stim_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
    end
  end

  assign {A1, A2, B1, B2, C1, C2} = r_stim;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign PASS     = r_pass;
  assign ERR_CNT  = r_err_cnt;
  assign FAIL_VEC = r_fail_vec;

endmodule
